// File: rtl/elevator_game_ctrl.sv
// Game-phase sequencer for the three-platform elevator scroller: tick divider, jump/land/death
// sequencing and score. Optional pause feature enabled by defining ELEVATOR_PAUSE_EN.
module elevator_game_ctrl #(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned JUMP_STEPS = 2,
    parameter int unsigned LAND_TOL   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       jump,
    input  logic       left,
    input  logic       right,
    input  logic       pause,
    input  logic [3:0] E1_Y,
    input  logic [3:0] E2_Y,
    input  logic [3:0] E3_Y,
    output logic [1:0] state,
    output logic [1:0] elev_state,
    output logic [1:0] player_lane,
    output logic [3:0] player_y,
    output logic [7:0] score
);

    localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned   JW        = $clog2(JUMP_STEPS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [JW-1:0] JUMP_INIT = JW'(JUMP_STEPS);
    localparam logic [3:0]    TOL       = 4'(LAND_TOL);

    typedef enum logic [1:0] {
        StStop = 2'b00,
        StMove = 2'b01,
        StElev = 2'b10,
        StDie  = 2'b11
    } state_t;

    state_t        r_state;
    logic [1:0]    r_lane;
    logic [3:0]    r_player_y;
    logic [7:0]    r_score;
    logic [TW-1:0] r_tick;
    logic [JW-1:0] r_jcnt;
    logic          r_start_d, r_jump_d, r_left_d, r_right_d;

    logic          w_active, w_paused, w_step;
    logic          w_start_e, w_jump_e, w_left_e, w_right_e;
    logic          w_in_elev, w_land_ok;
    logic [JW-1:0] w_jcnt_eff;
    logic [3:0]    w_lane_y, w_lane_y_inc, w_dist;
    logic [7:0]    w_score_inc;

    assign w_active = (r_state == StMove) || (r_state == StElev);

`ifdef ELEVATOR_PAUSE_EN
    logic r_pause_d, r_paused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pause_d <= 1'b0;
            r_paused  <= 1'b0;
        end else begin
            r_pause_d <= pause;
            // Leaving the active phases always clears the flag.
            if (!w_active)               r_paused <= 1'b0;
            else if (pause && !r_pause_d) r_paused <= ~r_paused;
        end
    end

    assign w_paused = r_paused && w_active;
`else
    logic w_unused_pause;
    assign w_unused_pause = pause;
    assign w_paused       = 1'b0;
`endif

    assign w_start_e = start & ~r_start_d & ~w_paused;
    assign w_jump_e  = jump  & ~r_jump_d  & ~w_paused;
    assign w_left_e  = left  & ~r_left_d  & ~w_paused;
    assign w_right_e = right & ~r_right_d & ~w_paused;

    assign w_step     = w_active && !w_paused && (r_tick == TICK_LAST);
    assign elev_state = w_step ? r_state : StStop;

    always_comb begin
        w_lane_y = E3_Y;
        case (r_lane)
            2'd0:    w_lane_y = E1_Y;
            2'd1:    w_lane_y = E2_Y;
            default: w_lane_y = E3_Y;
        endcase
    end

    assign w_lane_y_inc = (w_lane_y == 4'd11) ? 4'd0 : w_lane_y + 4'd1;
    assign w_dist       = (w_lane_y >= r_player_y) ? w_lane_y - r_player_y
                                                   : r_player_y - w_lane_y;
    assign w_land_ok    = (w_dist <= TOL);
    assign w_score_inc  = (r_score == 8'hFF) ? r_score : r_score + 8'd1;

    // A jump edge on a step cycle turns that step into the first Elevation step.
    assign w_in_elev  = (r_state == StElev) || ((r_state == StMove) && w_jump_e);
    assign w_jcnt_eff = (r_state == StMove) ? JUMP_INIT : r_jcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StStop;
            r_lane     <= 2'd0;
            r_player_y <= 4'd0;
            r_score    <= 8'd0;
            r_tick     <= '0;
            r_jcnt     <= '0;
            r_start_d  <= 1'b0;
            r_jump_d   <= 1'b0;
            r_left_d   <= 1'b0;
            r_right_d  <= 1'b0;
        end else begin
            r_start_d <= start;
            r_jump_d  <= jump;
            r_left_d  <= left;
            r_right_d <= right;

            if (w_active && !w_paused) r_tick <= w_step ? '0 : r_tick + TW'(1);

            case (r_state)
                StStop, StDie: begin
                    if (w_start_e) begin
                        r_state    <= StMove;
                        r_lane     <= 2'd0;
                        r_player_y <= E1_Y;
                        r_score    <= 8'd0;
                        r_tick     <= '0;
                        r_jcnt     <= '0;
                    end
                end
                default: begin
                    if (r_state == StElev && (w_left_e ^ w_right_e)) begin
                        if (w_left_e && r_lane != 2'd0)  r_lane <= r_lane - 2'd1;
                        if (w_right_e && r_lane != 2'd2) r_lane <= r_lane + 2'd1;
                    end
                    if (w_step) begin
                        if (w_in_elev) begin
                            r_jcnt <= w_jcnt_eff - JW'(1);
                            if (w_jcnt_eff == JW'(1)) begin
                                if (w_land_ok) begin
                                    r_state    <= StMove;
                                    r_player_y <= w_lane_y_inc;
                                    r_score    <= w_score_inc;
                                end else begin
                                    r_state <= StDie;
                                end
                            end else begin
                                r_state <= StElev;
                                r_score <= w_score_inc;
                            end
                        end else if (w_lane_y == 4'd11) begin
                            r_state <= StDie;
                        end else begin
                            r_player_y <= w_lane_y_inc;
                            r_score    <= w_score_inc;
                        end
                    end else if (r_state == StMove && w_jump_e) begin
                        r_state <= StElev;
                        r_jcnt  <= JUMP_INIT;
                    end
                end
            endcase
        end
    end

    assign state       = r_state;
    assign player_lane = r_lane;
    assign player_y    = r_player_y;
    assign score       = r_score;

endmodule

// File: tb/tb_elevator_game_ctrl.sv
// Table-driven bench for elevator_game_ctrl with default parameters (TICK_DIV=4,
// JUMP_STEPS=2, LAND_TOL=1); each vector pulses buttons for one clk then runs ncyc clks.
module tb_elevator_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, jump, left, right, pause;
    logic [3:0] E1_Y, E2_Y, E3_Y;
    logic [1:0] state, elev_state, player_lane;
    logic [3:0] player_y;
    logic [7:0] score;

    int n_vec = 0;
    int n_err = 0;

    elevator_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .jump       (jump),
        .left       (left),
        .right      (right),
        .pause      (pause),
        .E1_Y       (E1_Y),
        .E2_Y       (E2_Y),
        .E3_Y       (E3_Y),
        .state      (state),
        .elev_state (elev_state),
        .player_lane(player_lane),
        .player_y   (player_y),
        .score      (score)
    );

    always #5 clk = ~clk;

    // btn = {start, jump, left, right}
    typedef struct {
        logic [3:0] btn;
        logic [3:0] e1, e2, e3;
        int         ncyc;
        logic [1:0] st, el, ln;
        logic [3:0] y;
        logic [7:0] sc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int btn, int e1, int e2, int e3, int n,
                                int st, int el, int ln, int y, int sc);
        vec_t v;
        v.btn  = 4'(btn);
        v.e1   = 4'(e1);
        v.e2   = 4'(e2);
        v.e3   = 4'(e3);
        v.ncyc = n;
        v.st   = 2'(st);
        v.el   = 2'(el);
        v.ln   = 2'(ln);
        v.y    = 4'(y);
        v.sc   = 8'(sc);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        n_vec++;
        chk("state", idx, 8'(state), 8'(v.st));
        chk("elev_state", idx, 8'(elev_state), 8'(v.el));
        chk("player_lane", idx, 8'(player_lane), 8'(v.ln));
        chk("player_y", idx, 8'(player_y), 8'(v.y));
        chk("score", idx, score, v.sc);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        {start, jump, left, right} = v.btn;
        E1_Y = v.e1;
        E2_Y = v.e2;
        E3_Y = v.e3;
        @(negedge clk);
        {start, jump, left, right} = 4'b0000;
        repeat (v.ncyc - 1) @(negedge clk);
        check_all(idx, v);
    endtask

    initial begin
        vec_t zero_v;
        reset = 1'b1;
        {start, jump, left, right, pause} = 5'b0;
        E1_Y = 4'd0;
        E2_Y = 4'd0;
        E3_Y = 4'd0;

        //        btn     e1 e2 e3  n  st el ln  y  sc
        tv.push_back(mk(4'b0000,  2, 0, 0, 2, 0, 0, 0, 0, 0)); // idle in Stop
        tv.push_back(mk(4'b1000,  2, 0, 0, 1, 1, 0, 0, 2, 0)); // start
        tv.push_back(mk(4'b0000,  2, 0, 0, 3, 1, 1, 0, 2, 0)); // step pending
        tv.push_back(mk(4'b0000,  2, 0, 0, 1, 1, 0, 0, 3, 1)); // step 1
        for (int i = 0; i < 8; i++)
            tv.push_back(mk(4'b0000, 3 + i, 0, 0, 4, 1, 0, 0, 4 + i, 2 + i));
        tv.push_back(mk(4'b0000, 11, 0, 0, 4, 3, 0, 0, 11, 9)); // wraps off top
        tv.push_back(mk(4'b0000,  0, 0, 0, 3, 3, 0, 0, 11, 9)); // Die holds
        tv.push_back(mk(4'b1000,  5, 0, 0, 1, 1, 0, 0, 5, 0));  // restart
        tv.push_back(mk(4'b0100,  5, 0, 0, 4, 2, 0, 0, 5, 1));  // jump, 1st step
        tv.push_back(mk(4'b0001,  6, 5, 0, 4, 1, 0, 1, 6, 2));  // lane 1, land dist 0
        tv.push_back(mk(4'b0100,  7, 6, 0, 4, 2, 0, 1, 6, 3));  // jump again
        tv.push_back(mk(4'b0011,  7, 6, 0, 2, 2, 0, 1, 6, 3));  // left+right ignored
        tv.push_back(mk(4'b0001,  7, 6, 0, 1, 2, 2, 2, 6, 3));  // lane 2, step pending
        tv.push_back(mk(4'b0000,  7, 6, 7, 1, 1, 0, 2, 8, 4));  // land dist 1
        tv.push_back(mk(4'b0100,  7, 6, 8, 4, 2, 0, 2, 8, 5));  // jump on lane 2
        tv.push_back(mk(4'b0001,  7, 6, 9, 2, 2, 0, 2, 8, 5));  // right at lane 2 ignored
        tv.push_back(mk(4'b0010,  7, 11, 9, 2, 3, 0, 1, 8, 5)); // lane 1, dist 3 -> Die
        tv.push_back(mk(4'b0000,  7, 0, 9, 3, 3, 0, 1, 8, 5));  // Die holds
        tv.push_back(mk(4'b1000,  1, 0, 0, 2, 1, 0, 0, 1, 0));  // restart
        tv.push_back(mk(4'b1011,  1, 0, 0, 1, 1, 0, 0, 1, 0));  // start/left/right ignored
        tv.push_back(mk(4'b0100,  1, 0, 0, 1, 2, 2, 0, 1, 0));  // jump, step pending

        #2;
        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_all(-1, zero_v);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) run_vec(i, tv[i]);

        // Asynchronous reset during Elevation, checked before the next clk edge.
        #2 reset = 1'b1;
        #1 check_all(100, zero_v);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all(101, zero_v);

        // 260 steps on a safe lane: score saturates at 255.
        run_vec(102, mk(4'b1000, 3, 0, 0, 1041, 1, 0, 0, 4, 255));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
